// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forwarding-source encoding, mul/div sequencer states and register-match helpers.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
    return (rd != REG_ZERO) && (rd == src);
  endfunction

  // The younger producer (MEM) shadows the older one (WB).
  function automatic fwd_e_t fwd_pick(input logic             mem_we,
                                      input logic [REG_W-1:0] mem_rd,
                                      input logic             wb_we,
                                      input logic [REG_W-1:0] wb_rd,
                                      input logic [REG_W-1:0] src);
    if (mem_we && reg_hit(mem_rd, src)) return FWD_MEM;
    if (wb_we && reg_hit(wb_rd, src))   return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Sequencer for the shared multi-cycle mul/div unit.
// Issues a start pulse from IDLE, stays BUSY for MULDIV_CYCLES cycles, strobes HI/LO on the last one.
module hazard_ctrl_muldiv_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic start,
  output logic busy,
  output logic hilo_we
);

  localparam int unsigned CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  md_state_t     state;
  md_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // An issue arriving while BUSY is dropped rather than restarting the unit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (issue) begin
          start     = 1'b1;
          state_nxt = MD_BUSY;
          cnt_nxt   = CW'(MULDIV_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          hilo_we   = 1'b1;
          state_nxt = MD_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: load-use / branch-operand / mul-div stalls, EX and ID forwarding
// selects, mul/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_branch,
  input  logic             id_br_taken,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_is_muldiv,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             muldiv_start,
  output logic             muldiv_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_cnt
);

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  hazard_ctrl_muldiv_seq #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_seq (
    .clk    (clk),
    .reset  (reset),
    .issue  (ex_is_muldiv),
    .start  (muldiv_start),
    .busy   (muldiv_busy),
    .hilo_we(hilo_we)
  );

  // Branches compare in ID, so an EX producer or an in-flight load in MEM is not yet forwardable.
  always_comb begin
    lw_stall = ex_mem_read &
               ((id_use_rs & reg_hit(ex_rd, id_rs)) | (id_use_rt & reg_hit(ex_rd, id_rt)));
    br_stall = id_is_branch &
               ((ex_reg_write & (reg_hit(ex_rd, id_rs) | reg_hit(ex_rd, id_rt))) |
                (mem_mem_read & (reg_hit(mem_rd, id_rs) | reg_hit(mem_rd, id_rt))));
    md_stall = (id_is_muldiv | id_reads_hilo) & (muldiv_busy | muldiv_start);
    stall    = lw_stall | br_stall | md_stall;
  end

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  // A stalled branch has not resolved yet, so it must not squash the fetch.
  assign flush_d = id_is_branch & id_br_taken & ~stall;

  assign fwd_a_e = fwd_pick(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rs);
  assign fwd_b_e = fwd_pick(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rt);

  // Only an ALU result is ready in MEM; load data arrives too late for the ID comparator.
  assign fwd_a_d = mem_reg_write & ~mem_mem_read & reg_hit(mem_rd, id_rs);
  assign fwd_b_d = mem_reg_write & ~mem_mem_read & reg_hit(mem_rd, id_rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and narrow-counter / short mul-div) checked each
// cycle against a behavioural model, plus directed literal scenarios.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_is_branch, id_br_taken, id_is_muldiv, id_reads_hilo;
  logic ex_reg_write, ex_mem_read, ex_is_muldiv, mem_reg_write, mem_mem_read, wb_reg_write;

  logic       stall_f [2];
  logic       stall_d [2];
  logic       flush_d [2];
  logic       flush_e [2];
  logic [1:0] fwd_a_e [2];
  logic [1:0] fwd_b_e [2];
  logic       fwd_a_d [2];
  logic       fwd_b_d [2];
  logic       md_start [2];
  logic       md_busy [2];
  logic       hilo [2];
  logic [31:0] scnt0;
  logic [2:0]  scnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_f(stall_f[0]), .stall_d(stall_d[0]), .flush_d(flush_d[0]), .flush_e(flush_e[0]),
    .fwd_a_e(fwd_a_e[0]), .fwd_b_e(fwd_b_e[0]), .fwd_a_d(fwd_a_d[0]), .fwd_b_d(fwd_b_d[0]),
    .muldiv_start(md_start[0]), .muldiv_busy(md_busy[0]), .hilo_we(hilo[0]),
    .stall_cnt(scnt0)
  );

  hazard_ctrl #(.MULDIV_CYCLES(2), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_f(stall_f[1]), .stall_d(stall_d[1]), .flush_d(flush_d[1]), .flush_e(flush_e[1]),
    .fwd_a_e(fwd_a_e[1]), .fwd_b_e(fwd_b_e[1]), .fwd_a_d(fwd_a_d[1]), .fwd_b_d(fwd_b_d[1]),
    .muldiv_start(md_start[1]), .muldiv_busy(md_busy[1]), .hilo_we(hilo[1]),
    .stall_cnt(scnt1)
  );

  // ---------------- behavioural model ----------------
  int              n_cyc [2] = '{4, 2};
  longint unsigned cmax  [2] = '{64'hFFFF_FFFF, 64'd7};
  int              rem   [2] = '{0, 0};   // busy cycles still to come
  longint unsigned mcnt  [2] = '{0, 0};

  function automatic bit hit(input logic [4:0] rd, input logic [4:0] src);
    return rd != 5'd0 && rd == src;
  endfunction

  function automatic int fwd_exp(input logic [4:0] src);
    if (mem_reg_write && hit(mem_rd, src)) return 2;
    if (wb_reg_write && hit(wb_rd, src)) return 1;
    return 0;
  endfunction

  function automatic bit start_exp(input int i);
    return ex_is_muldiv && rem[i] == 0;
  endfunction

  function automatic bit stall_exp(input int i);
    bit lw, br, md;
    lw = ex_mem_read && ((id_use_rs && hit(ex_rd, id_rs)) || (id_use_rt && hit(ex_rd, id_rt)));
    br = id_is_branch && ((ex_reg_write && (hit(ex_rd, id_rs) || hit(ex_rd, id_rt))) ||
                          (mem_mem_read && (hit(mem_rd, id_rs) || hit(mem_rd, id_rt))));
    md = (id_is_muldiv || id_reads_hilo) && (rem[i] > 0 || start_exp(i));
    return lw || br || md;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rem[i]  = 0;
        mcnt[i] = 0;
      end else begin
        if (stall_exp(i) && mcnt[i] != cmax[i]) mcnt[i] = mcnt[i] + 1;
        if (start_exp(i)) rem[i] = n_cyc[i];
        else if (rem[i] > 0) rem[i] = rem[i] - 1;
      end
    end
  end

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit st;
      st = stall_exp(i);
      chk("stall_f", i, stall_f[i], st);
      chk("stall_d", i, stall_d[i], st);
      chk("flush_e", i, flush_e[i], st);
      chk("flush_d", i, flush_d[i], id_is_branch && id_br_taken && !st);
      chk("fwd_a_e", i, fwd_a_e[i], fwd_exp(ex_rs));
      chk("fwd_b_e", i, fwd_b_e[i], fwd_exp(ex_rt));
      chk("fwd_a_d", i, fwd_a_d[i], mem_reg_write && !mem_mem_read && hit(mem_rd, id_rs));
      chk("fwd_b_d", i, fwd_b_d[i], mem_reg_write && !mem_mem_read && hit(mem_rd, id_rt));
      chk("muldiv_start", i, md_start[i], start_exp(i));
      chk("muldiv_busy", i, md_busy[i], rem[i] > 0);
      chk("hilo_we", i, hilo[i], rem[i] == 1);
      chk("stall_cnt", i, (i == 0) ? longint'(scnt0) : longint'(scnt1), longint'(mcnt[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs, id_use_rt, id_is_branch, id_br_taken, id_is_muldiv, id_reads_hilo} = '0;
    {ex_reg_write, ex_mem_read, ex_is_muldiv, mem_reg_write, mem_mem_read, wb_reg_write} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rst_busy", 0, md_busy[0], 0);
    chk("rst_hilo", 0, hilo[0], 0);
    chk("rst_cnt", 0, scnt0, 0);

    // Load-use, then the load moves to MEM and feeds EX operand A.
    next_cycle();
    reset = 1'b0;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    @(negedge clk);
    chk("lu_stall_f", 0, stall_f[0], 1);
    chk("lu_stall_d", 0, stall_d[0], 1);
    chk("lu_flush_e", 0, flush_e[0], 1);
    next_cycle();
    clear_inputs();
    mem_rd = 8; mem_reg_write = 1; mem_mem_read = 1; ex_rs = 8;
    @(negedge clk);
    chk("lu_fwd_mem", 0, fwd_a_e[0], 2);
    chk("lu_released", 0, stall_d[0], 0);
    chk("lu_cnt", 0, scnt0, 1);

    // Forwarding priority.
    next_cycle();
    clear_inputs();
    mem_rd = 9; wb_rd = 9; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 9;
    @(negedge clk);
    chk("prio_mem", 0, fwd_a_e[0], 2);
    next_cycle();
    mem_reg_write = 0;
    @(negedge clk);
    chk("prio_wb", 0, fwd_a_e[0], 1);
    next_cycle();
    mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
    @(negedge clk);
    chk("prio_zero", 0, fwd_a_e[0], 0);

    // Branch operand hazards.
    next_cycle();
    clear_inputs();
    id_is_branch = 1; id_br_taken = 1; id_rs = 10; ex_rd = 10; ex_reg_write = 1;
    @(negedge clk);
    chk("br_stall", 0, stall_d[0], 1);
    chk("br_noflush", 0, flush_d[0], 0);
    next_cycle();
    ex_rd = 0; ex_reg_write = 0; mem_rd = 10; mem_reg_write = 1;
    @(negedge clk);
    chk("br_fwd_d", 0, fwd_a_d[0], 1);
    chk("br_nostall", 0, stall_d[0], 0);
    chk("br_flush", 0, flush_d[0], 1);

    // Mul/div with mfhi waiting in ID: 5 stalled cycles.
    do_reset();
    ex_is_muldiv = 1; id_reads_hilo = 1;
    @(negedge clk);
    chk("md_start", 0, md_start[0], 1);
    chk("md_start_stall", 0, stall_d[0], 1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      ex_is_muldiv = 0;
      @(negedge clk);
      chk("md_busy", 0, md_busy[0], 1);
      chk("md_hilo", 0, hilo[0], (k == 4) ? 1 : 0);
      chk("md_stall", 0, stall_d[0], 1);
    end
    next_cycle();
    @(negedge clk);
    chk("md_idle", 0, md_busy[0], 0);
    chk("md_nostall", 0, stall_d[0], 0);
    chk("md_cnt", 0, scnt0, 5);

    // Reset during the second busy cycle, then a clean restart.
    do_reset();
    ex_is_muldiv = 1; id_reads_hilo = 1;
    next_cycle();
    ex_is_muldiv = 0;
    @(negedge clk);
    chk("mr_busy1", 0, md_busy[0], 1);
    chk("mr_cnt1", 0, scnt0, 1);
    next_cycle();
    reset = 1;
    @(negedge clk);
    chk("mr_rst_busy", 0, md_busy[0], 0);
    chk("mr_rst_cnt", 0, scnt0, 0);
    next_cycle();
    reset = 0; id_reads_hilo = 0; ex_is_muldiv = 1;
    @(negedge clk);
    chk("mr_restart", 0, md_start[0], 1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      ex_is_muldiv = 0;
      @(negedge clk);
      chk("mr_busy", 0, md_busy[0], 1);
      chk("mr_hilo", 0, hilo[0], (k == 4) ? 1 : 0);
    end
    next_cycle();
    @(negedge clk);
    chk("mr_done", 0, md_busy[0], 0);

    // Counter saturation on the 3-bit instance.
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    for (int k = 0; k < 10; k++) next_cycle();
    @(negedge clk);
    chk("sat_wide", 0, scnt0, 10);
    chk("sat_narrow", 1, scnt1, 7);
    next_cycle();
    @(negedge clk);
    chk("sat_hold", 1, scnt1, 7);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset         = ($urandom_range(0, 99) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rs         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      id_use_rs     = 1'($urandom);
      id_use_rt     = 1'($urandom);
      id_is_branch  = ($urandom_range(0, 3) == 0);
      id_br_taken   = 1'($urandom);
      id_is_muldiv  = ($urandom_range(0, 5) == 0);
      id_reads_hilo = ($urandom_range(0, 5) == 0);
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_is_muldiv  = ($urandom_range(0, 7) == 0);
      mem_reg_write = 1'($urandom);
      mem_mem_read  = ($urandom_range(0, 2) == 0);
      wb_reg_write  = 1'($urandom);
    end

    next_cycle();
    reset = 0;
    clear_inputs();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
